// File: rtl/ulpi_reg_sched.sv
`timescale 1ns/1ps
// ULPI register scheduler: PHY init sequence, then one user port.
// Ports: CLK_60M/NRST_A_USB; REG_* to the link wrapper; USR_* user
//   port; INIT_DONE/INIT_ERR/BUSY status.
// Option: ULPI_REG_SCHED_VERIFY_EN adds a readback after every write.
module ulpi_reg_sched #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic       READY,
  input  logic       REG_DONE,
  input  logic       REG_FAIL,
  input  logic [7:0] REG_DATA_O,
  output logic       REG_EN,
  output logic       REG_RW,
  output logic [5:0] REG_ADDR,
  output logic [7:0] REG_DATA_I,
  input  logic       USR_REQ,
  input  logic       USR_RW,
  input  logic [5:0] USR_ADDR,
  input  logic [7:0] USR_WDATA,
  output logic       USR_GNT,
  output logic       USR_DONE,
  output logic       USR_ERR,
  output logic [7:0] USR_RDATA,
  output logic       INIT_DONE,
  output logic       INIT_ERR,
  output logic       BUSY
);

`ifdef ULPI_REG_SCHED_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_BOOT, S_ISSUE, S_WAIT, S_CHECK,
    S_RETRY, S_SETTLE, S_IDLE
  } state_t;

  // What SETTLE does once the bus is quiet
  typedef enum logic [1:0] {
    A_NEXT, A_AGAIN, A_VFY, A_FAIL
  } act_t;

  state_t state_q, state_d;
  act_t   act_q, act_d;

  logic [1:0]  idx_q, nidx;
  logic        usr_q, vfy_q;
  logic        rw_q;
  logic [5:0]  addr_q;
  logic [7:0]  data_q, rd_q, rdata_q;
  logic [3:0]  att_q;
  logic [15:0] tmo_q;
  logic        en_q, gnt_q;
  logic        init_done_q, init_err_q;

  logic ld_init, ld_usr, ld_vfy, ld_again;
  logic rd_latch, urd_latch;
  logic set_done, set_err;
  logic usr_done, usr_err;
  logic wfail;

  // {rw, addr, data}; for the vendor read, data is the expected ID
  function automatic logic [14:0] init_ent(input logic [1:0] i);
    logic [14:0] e;
    case (i)
      2'd0:    e = {1'b1, 6'h04, 8'h45};
      2'd1:    e = {1'b1, 6'h0A, 8'h00};
      2'd2:    e = {1'b1, 6'h07, 8'h00};
      default: e = {1'b0, 6'h00, 8'h24};
    endcase
    return e;
  endfunction

  // DONE together with the timeout expiring still counts as success
  assign wfail = REG_FAIL |
    (!REG_DONE && (tmo_q >= 16'(TIMEOUT)));

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q <= S_BOOT;
      act_q   <= A_NEXT;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    nidx      = 2'd0;
    ld_init   = 1'b0;
    ld_usr    = 1'b0;
    ld_vfy    = 1'b0;
    ld_again  = 1'b0;
    rd_latch  = 1'b0;
    urd_latch = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;
    usr_done  = 1'b0;
    usr_err   = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        if (READY) begin
          ld_init = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (wfail) begin
          state_d = S_RETRY;
        end else if (REG_DONE) begin
          state_d = S_SETTLE;
          act_d   = A_NEXT;
          if (rw_q) begin
            if (VFY) act_d = A_VFY;
          end else if (usr_q && !vfy_q) begin
            urd_latch = 1'b1;
          end else begin
            rd_latch = 1'b1;
            state_d  = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (rd_q != data_q) begin
          state_d = S_RETRY;
        end else begin
          act_d   = A_NEXT;
          state_d = S_SETTLE;
        end
      end
      S_RETRY: begin
        state_d = S_SETTLE;
        if (att_q < 4'(MAX_RETRY)) begin
          act_d = A_AGAIN;
        end else begin
          act_d   = A_FAIL;
          set_err = !usr_q;
        end
      end
      S_SETTLE: begin
        if (!REG_DONE && READY) begin
          unique case (act_q)
            A_AGAIN: begin
              ld_again = 1'b1;
              state_d  = S_ISSUE;
            end
            A_VFY: begin
              ld_vfy  = 1'b1;
              state_d = S_ISSUE;
            end
            default: begin
              if (usr_q) begin
                usr_done = 1'b1;
                usr_err  = (act_q == A_FAIL);
                state_d  = S_IDLE;
              end else if (act_q == A_FAIL ||
                           idx_q == 2'd3) begin
                set_done = 1'b1;
                state_d  = S_IDLE;
              end else begin
                nidx    = idx_q + 2'd1;
                ld_init = 1'b1;
                state_d = S_ISSUE;
              end
            end
          endcase
        end
      end
      S_IDLE: begin
        if (USR_REQ && READY && init_done_q) begin
          ld_usr  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      idx_q       <= '0;
      usr_q       <= 1'b0;
      vfy_q       <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_q        <= '0;
      rdata_q     <= '0;
      att_q       <= '0;
      tmo_q       <= '0;
      en_q        <= 1'b0;
      gnt_q       <= 1'b0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
    end else begin
      en_q  <= (state_q == S_ISSUE);
      gnt_q <= ld_usr;
      if (state_q == S_ISSUE) begin
        tmo_q <= '0;
      end else if (state_q == S_WAIT && tmo_q != '1) begin
        tmo_q <= tmo_q + 16'd1;
      end
      if (ld_init) begin
        {rw_q, addr_q, data_q} <= init_ent(nidx);
        idx_q <= nidx;
        usr_q <= 1'b0;
        vfy_q <= 1'b0;
        att_q <= '0;
      end
      if (ld_usr) begin
        rw_q   <= USR_RW;
        addr_q <= USR_ADDR;
        data_q <= USR_WDATA;
        usr_q  <= 1'b1;
        vfy_q  <= 1'b0;
        att_q  <= '0;
      end
      if (ld_vfy) begin
        rw_q  <= 1'b0;
        vfy_q <= 1'b1;
      end
      // A failed readback retries the original write
      if (ld_again) begin
        att_q <= att_q + 4'd1;
        if (vfy_q) begin
          rw_q  <= 1'b1;
          vfy_q <= 1'b0;
        end
      end
      if (rd_latch)  rd_q <= REG_DATA_O;
      if (urd_latch) rdata_q <= REG_DATA_O;
      if (set_done)  init_done_q <= 1'b1;
      if (set_err)   init_err_q <= 1'b1;
    end
  end

  assign REG_EN     = en_q;
  assign REG_RW     = rw_q;
  assign REG_ADDR   = addr_q;
  assign REG_DATA_I = data_q;
  assign USR_GNT    = gnt_q;
  assign USR_DONE   = usr_done;
  assign USR_ERR    = usr_err;
  assign USR_RDATA  = rdata_q;
  assign INIT_DONE  = init_done_q;
  assign INIT_ERR   = init_err_q;
  assign BUSY = !(state_q == S_IDLE && init_done_q);

endmodule
